// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding and field widths for the lock controller
package lock_pkg;

    localparam int TICKS_W  = 6;
    localparam int FAIL_W   = 2;
    localparam int STREAK_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2,
        ST_ALARM   = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_sync.sv
// rtl/pulse_sync.sv - two-flop synchronizer with rising-edge one-cycle pulse
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Two synchronizer stages, then one history flop so a held level pulses once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_level;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/lock_ctrl.sv
// rtl/lock_ctrl.sv - door lock sequencer with open timer, lockout and alarm
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int TICK_DIV   = 100000000,
    parameter int OPEN_TICKS = 5,
    parameter int LOCK_TICKS = 30,
    parameter int MAX_FAIL   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pass,
    input  logic               fail,
    output logic               unlocked,
    output logic               locked_out,
    output logic               alarm,
    output logic [FAIL_W-1:0]  fail_cnt,
    output logic [TICKS_W-1:0] ticks_left
);

    localparam int                   PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [TICKS_W-1:0]   OPEN_LOAD  = TICKS_W'(OPEN_TICKS);
    localparam logic [TICKS_W-1:0]   LOCK_LOAD  = TICKS_W'(LOCK_TICKS);
    localparam logic [FAIL_W:0]      FAIL_LIMIT = (FAIL_W + 1)'(MAX_FAIL);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PRESC_W-1:0]  r_presc;
    logic [PRESC_W-1:0]  w_presc_nxt;
    logic [TICKS_W-1:0]  r_ticks;
    logic [TICKS_W-1:0]  w_ticks_nxt;
    logic [FAIL_W-1:0]   r_fail_cnt;
    logic [FAIL_W-1:0]   w_fail_cnt_nxt;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_nxt;
    logic                r_alarm;
    logic                w_alarm_nxt;
    logic                w_pass_p;
    logic                w_fail_p;
    logic                w_tick;
    logic [FAIL_W:0]     w_fail_inc;

    pulse_sync u_pass_sync (
        .clk     (clk),
        .rst     (rst),
        .i_level (pass),
        .o_pulse (w_pass_p)
    );

    pulse_sync u_fail_sync (
        .clk     (clk),
        .rst     (rst),
        .i_level (fail),
        .o_pulse (w_fail_p)
    );

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_fail_inc = {1'b0, r_fail_cnt} + 1'b1;

    // State, prescaler, timer and counters all advance together on the clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_ticks    <= '0;
            r_fail_cnt <= '0;
            r_streak   <= '0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_ticks    <= w_ticks_nxt;
            r_fail_cnt <= w_fail_cnt_nxt;
            r_streak   <= w_streak_nxt;
            r_alarm    <= w_alarm_nxt;
        end
    end

    // Next-state decision; a fail pulse wins over a coincident pass pulse
    always_comb begin
        w_state_nxt    = r_state;
        w_presc_nxt    = w_tick ? '0 : r_presc + 1'b1;
        w_ticks_nxt    = r_ticks;
        w_fail_cnt_nxt = r_fail_cnt;
        w_streak_nxt   = r_streak;
        w_alarm_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_fail_p) begin
                    if (w_fail_inc >= FAIL_LIMIT) begin
                        w_fail_cnt_nxt = '0;
                        w_presc_nxt    = '0;
                        w_streak_nxt   = (r_streak == '1) ? r_streak : r_streak + 1'b1;
                        if (r_streak != '0) begin
                            w_state_nxt = ST_ALARM;
                            w_ticks_nxt = '0;
                        end else begin
                            w_state_nxt = ST_LOCKOUT;
                            w_ticks_nxt = LOCK_LOAD;
                        end
                    end else begin
                        w_fail_cnt_nxt = (r_fail_cnt == '1) ? r_fail_cnt : r_fail_cnt + 1'b1;
                    end
                end else if (w_pass_p) begin
                    w_state_nxt    = ST_OPEN;
                    w_ticks_nxt    = OPEN_LOAD;
                    w_presc_nxt    = '0;
                    w_fail_cnt_nxt = '0;
                    w_streak_nxt   = '0;
                end
            end
            ST_OPEN: begin
                if (w_fail_p) begin
                    w_state_nxt = ST_IDLE;
                    w_ticks_nxt = '0;
                    w_presc_nxt = '0;
                end else if (w_pass_p) begin
                    w_ticks_nxt = OPEN_LOAD;
                    w_presc_nxt = '0;
                end else if (w_tick) begin
                    if (r_ticks <= 1) begin
                        w_state_nxt = ST_IDLE;
                        w_ticks_nxt = '0;
                    end else begin
                        w_ticks_nxt = r_ticks - 1'b1;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (w_tick) begin
                    if (r_ticks <= 1) begin
                        w_state_nxt = ST_IDLE;
                        w_ticks_nxt = '0;
                    end else begin
                        w_ticks_nxt = r_ticks - 1'b1;
                    end
                end
            end
            ST_ALARM: begin
                w_alarm_nxt = r_alarm ^ w_tick;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ticks_nxt = '0;
            end
        endcase
    end

    assign unlocked   = (r_state == ST_OPEN);
    assign locked_out = (r_state == ST_LOCKOUT);
    assign alarm      = r_alarm;
    assign fail_cnt   = r_fail_cnt;
    assign ticks_left = r_ticks;

endmodule

// File: tb/tb_lock_ctrl.sv
// tb/tb_lock_ctrl.sv - directed self-checking bench for lock_ctrl
module tb_lock_ctrl;

    logic       clk;
    logic       rst;
    logic       pass;
    logic       fail;
    logic       unlocked;
    logic       locked_out;
    logic       alarm;
    logic [1:0] fail_cnt;
    logic [5:0] ticks_left;

    int checks;
    int errors;

    lock_ctrl #(
        .TICK_DIV   (4),
        .OPEN_TICKS (2),
        .LOCK_TICKS (3),
        .MAX_FAIL   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pass       (pass),
        .fail       (fail),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .alarm      (alarm),
        .fail_cnt   (fail_cnt),
        .ticks_left (ticks_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_rise(input logic p, input logic f);
        @(negedge clk);
        pass = p;
        fail = f;
        edges(3);
    endtask

    task automatic release_inputs();
        pass = 1'b0;
        fail = 1'b0;
        edges(3);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        pass = 1'b0;
        fail = 1'b0;
        edges(3);
        checks++;
        if ({unlocked, locked_out, alarm, fail_cnt, ticks_left} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {unlocked, locked_out, alarm, fail_cnt, ticks_left});
        end
        @(negedge clk);
        rst = 1'b0;
        edges(2);
        checks++;
        if ({unlocked, locked_out, alarm, fail_cnt, ticks_left} !== 11'd0) begin
            errors++;
            $display("FAIL post_reset_idle got=%b exp=0", {unlocked, locked_out, alarm, fail_cnt, ticks_left});
        end
    endtask

    task automatic test_open();
        @(negedge clk);
        pass = 1'b1;
        edges(2);
        checks++;
        if (unlocked !== 1'b0) begin
            errors++;
            $display("FAIL open_latency_edge2 unlocked=%b exp=0", unlocked);
        end
        edges(1);
        checks++;
        if (unlocked !== 1'b1 || ticks_left !== 6'd2) begin
            errors++;
            $display("FAIL open_entry unlocked=%b ticks=%0d exp 1,2", unlocked, ticks_left);
        end
        pass = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            edges(1);
            if (i == 4) begin
                checks++;
                if (ticks_left !== 6'd1) begin
                    errors++;
                    $display("FAIL open_tick1 ticks=%0d exp=1", ticks_left);
                end
            end
            if (i == 7) begin
                checks++;
                if (unlocked !== 1'b1) begin
                    errors++;
                    $display("FAIL open_hold7 unlocked=%b exp=1", unlocked);
                end
            end
            if (i == 8) begin
                checks++;
                if (unlocked !== 1'b0 || ticks_left !== 6'd0) begin
                    errors++;
                    $display("FAIL open_exit8 unlocked=%b ticks=%0d exp 0,0", unlocked, ticks_left);
                end
            end
        end
    endtask

    task automatic test_lockout();
        drive_rise(1'b0, 1'b1);
        checks++;
        if (fail_cnt !== 2'd1) begin
            errors++;
            $display("FAIL lock_fail1 fail_cnt=%0d exp=1", fail_cnt);
        end
        release_inputs();
        drive_rise(1'b0, 1'b1);
        checks++;
        if (fail_cnt !== 2'd2) begin
            errors++;
            $display("FAIL lock_fail2 fail_cnt=%0d exp=2", fail_cnt);
        end
        release_inputs();
        drive_rise(1'b0, 1'b1);
        checks++;
        if (locked_out !== 1'b1 || fail_cnt !== 2'd0 || ticks_left !== 6'd3) begin
            errors++;
            $display("FAIL lock_entry locked_out=%b fail_cnt=%0d ticks=%0d exp 1,0,3", locked_out, fail_cnt, ticks_left);
        end
        release_inputs();
        drive_rise(1'b1, 1'b0);
        checks++;
        if (locked_out !== 1'b1 || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL lock_pass_ignored locked_out=%b unlocked=%b exp 1,0", locked_out, unlocked);
        end
        release_inputs();
        edges(2);
        checks++;
        if (locked_out !== 1'b1 || ticks_left !== 6'd1) begin
            errors++;
            $display("FAIL lock_hold11 locked_out=%b ticks=%0d exp 1,1", locked_out, ticks_left);
        end
        edges(1);
        checks++;
        if (locked_out !== 1'b0 || ticks_left !== 6'd0 || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL lock_exit12 locked_out=%b ticks=%0d unlocked=%b exp 0,0,0", locked_out, ticks_left, unlocked);
        end
        edges(2);
        checks++;
        if (unlocked !== 1'b0) begin
            errors++;
            $display("FAIL lock_pass_not_queued unlocked=%b exp=0", unlocked);
        end
    endtask

    task automatic test_alarm();
        drive_rise(1'b0, 1'b1);
        release_inputs();
        drive_rise(1'b0, 1'b1);
        checks++;
        if (fail_cnt !== 2'd2) begin
            errors++;
            $display("FAIL alarm_fail2 fail_cnt=%0d exp=2", fail_cnt);
        end
        release_inputs();
        drive_rise(1'b0, 1'b1);
        checks++;
        if (locked_out !== 1'b0 || alarm !== 1'b0 || ticks_left !== 6'd0 || fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL alarm_entry locked_out=%b alarm=%b ticks=%0d fail_cnt=%0d exp 0,0,0,0", locked_out, alarm, ticks_left, fail_cnt);
        end
        release_inputs();
        edges(1);
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_toggle1 alarm=%b exp=1", alarm);
        end
        edges(3);
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_hold alarm=%b exp=1", alarm);
        end
        edges(1);
        checks++;
        if (alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_toggle2 alarm=%b exp=0", alarm);
        end
        drive_rise(1'b1, 1'b0);
        edges(1);
        checks++;
        if (alarm !== 1'b1 || unlocked !== 1'b0 || locked_out !== 1'b0) begin
            errors++;
            $display("FAIL alarm_ignores_pass alarm=%b unlocked=%b locked_out=%b exp 1,0,0", alarm, unlocked, locked_out);
        end
        @(negedge clk);
        rst  = 1'b1;
        pass = 1'b0;
        #1;
        checks++;
        if ({unlocked, locked_out, alarm, fail_cnt, ticks_left} !== 11'd0) begin
            errors++;
            $display("FAIL alarm_reset got=%b exp=0", {unlocked, locked_out, alarm, fail_cnt, ticks_left});
        end
        edges(2);
        @(negedge clk);
        rst = 1'b0;
        edges(3);
    endtask

    task automatic test_simultaneous();
        drive_rise(1'b1, 1'b1);
        checks++;
        if (fail_cnt !== 2'd1 || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL simul_is_fail fail_cnt=%0d unlocked=%b exp 1,0", fail_cnt, unlocked);
        end
        release_inputs();
    endtask

    task automatic test_open_restart_fail();
        drive_rise(1'b1, 1'b0);
        checks++;
        if (unlocked !== 1'b1 || fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL restart_entry unlocked=%b fail_cnt=%0d exp 1,0", unlocked, fail_cnt);
        end
        release_inputs();
        drive_rise(1'b1, 1'b0);
        checks++;
        if (ticks_left !== 6'd2 || unlocked !== 1'b1) begin
            errors++;
            $display("FAIL restart_reload ticks=%0d unlocked=%b exp 2,1", ticks_left, unlocked);
        end
        release_inputs();
        checks++;
        if (ticks_left !== 6'd2) begin
            errors++;
            $display("FAIL restart_prescaler ticks=%0d exp=2", ticks_left);
        end
        drive_rise(1'b0, 1'b1);
        checks++;
        if (unlocked !== 1'b0 || fail_cnt !== 2'd0 || ticks_left !== 6'd0) begin
            errors++;
            $display("FAIL open_fail_exit unlocked=%b fail_cnt=%0d ticks=%0d exp 0,0,0", unlocked, fail_cnt, ticks_left);
        end
        release_inputs();
    endtask

    task automatic test_reset_mid_open();
        int seen;
        drive_rise(1'b0, 1'b1);
        release_inputs();
        drive_rise(1'b1, 1'b0);
        edges(4);
        checks++;
        if (unlocked !== 1'b1 || ticks_left !== 6'd1) begin
            errors++;
            $display("FAIL midopen_pre unlocked=%b ticks=%0d exp 1,1", unlocked, ticks_left);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({unlocked, locked_out, alarm, fail_cnt, ticks_left} !== 11'd0) begin
            errors++;
            $display("FAIL midopen_reset got=%b exp=0", {unlocked, locked_out, alarm, fail_cnt, ticks_left});
        end
        edges(2);
        @(negedge clk);
        rst = 1'b0;
        edges(2);
        checks++;
        if (unlocked !== 1'b0) begin
            errors++;
            $display("FAIL held_pass_edge2 unlocked=%b exp=0", unlocked);
        end
        edges(1);
        checks++;
        if (unlocked !== 1'b1 || ticks_left !== 6'd2) begin
            errors++;
            $display("FAIL held_pass_entry unlocked=%b ticks=%0d exp 1,2", unlocked, ticks_left);
        end
        edges(8);
        checks++;
        if (unlocked !== 1'b0) begin
            errors++;
            $display("FAIL held_pass_exit unlocked=%b exp=0", unlocked);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            if (unlocked === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL held_pass_single_entry extra_open_cycles=%0d exp=0", seen);
        end
        release_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_open();
        test_lockout();
        test_alarm();
        test_simultaneous();
        test_open_restart_fail();
        test_reset_mid_open();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_ctrl.md
LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per timer tick (1 s at 100 MHz).
REQ-002 SHALL have parameter OPEN_TICKS, default 5, ticks the lock stays open after a pass.
REQ-003 SHALL have parameter LOCK_TICKS, default 30, ticks of lockout after MAX_FAIL failures.
REQ-004 SHALL have parameter MAX_FAIL, default 3, consecutive failures that trigger a lockout.
REQ-005 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port pass, input, 1, level from the upstream code-judge stage, asynchronous to clk.
REQ-008 SHALL have port fail, input, 1, level from the upstream code-judge stage, asynchronous to clk.
REQ-009 SHALL have port unlocked, output, 1, high while in OPEN.
REQ-010 SHALL have port locked_out, output, 1, high while in LOCKOUT.
REQ-011 SHALL have port alarm, output, 1, blinking indicator while in ALARM.
REQ-012 SHALL have port fail_cnt, output, 2, consecutive failures in the current attempt series.
REQ-013 SHALL have port ticks_left, output, 6, remaining ticks of OPEN or LOCKOUT, 0 otherwise.

Function
REQ-014 SHALL pass each of pass and fail through a 2-flop synchronizer, then a rising-edge detector giving a 1-cycle pulse; a level held high produces exactly one pulse.
REQ-015 SHALL register the state change on the 3rd rising clk edge after an input rise that meets setup (2 sync edges plus 1 decision edge).
REQ-016 SHALL implement states IDLE, OPEN, LOCKOUT and ALARM, with IDLE after reset.
REQ-017 In IDLE, a pass pulse SHALL enter OPEN, clear fail_cnt and clear lock_streak.
REQ-018 In IDLE, a fail pulse SHALL increment fail_cnt; on reaching MAX_FAIL it SHALL enter LOCKOUT, clear fail_cnt and increment lock_streak.
REQ-019 A second consecutive lockout (lock_streak reaching 2 with no intervening pass) SHALL enter ALARM instead of LOCKOUT.
REQ-020 In OPEN, a pass pulse SHALL restart the OPEN timer, and a fail pulse SHALL return to IDLE immediately without changing fail_cnt.
REQ-021 OPEN SHALL last exactly OPEN_TICKS*TICK_DIV cycles, then return to IDLE.
REQ-022 In LOCKOUT, pass and fail pulses SHALL be ignored and discarded, not queued.
REQ-023 LOCKOUT SHALL last exactly LOCK_TICKS*TICK_DIV cycles, then return to IDLE with lock_streak retained.
REQ-024 In ALARM, alarm SHALL toggle on every tick, all inputs SHALL be ignored, and only rst SHALL exit the state.
REQ-025 The prescaler SHALL run 0..TICK_DIV-1, wrap with a 1-cycle tick, and restart at 0 on every state entry or timer restart.
REQ-026 ticks_left SHALL load OPEN_TICKS or LOCK_TICKS on entry and decrement on each tick; the state SHALL exit on the tick that takes it to 0.
REQ-027 Simultaneous pass and fail pulses SHALL be treated as fail.
REQ-028 fail_cnt SHALL saturate and never wrap, since MAX_FAIL is at most 3.

Reset
REQ-029 rst SHALL immediately force IDLE with unlocked=0, locked_out=0, alarm=0, fail_cnt=0, ticks_left=0, lock_streak=0, prescaler=0 and synchronizer/edge flops=0.
REQ-030 rst asserted mid-OPEN, mid-LOCKOUT or in ALARM SHALL behave identically to a power-on reset.
REQ-031 On rst release, an input held high SHALL produce one pulse once synchronized.

Structure
REQ-032 Package lock_pkg SHALL hold the state encoding, TICKS_W=6 and FAIL_W=2.
REQ-033 Sub-module pulse_sync (2-flop synchronizer plus rising-edge detector) SHALL be instantiated once for pass and once for fail.

Verification
REQ-034 All scenarios SHALL use TICK_DIV=4, OPEN_TICKS=2, LOCK_TICKS=3, MAX_FAIL=3.
REQ-035 pass rise from IDLE -> unlocked=1 on 3rd edge, ticks_left=2, unlocked=0 exactly 8 cycles later, state IDLE.
REQ-036 3 separate fail rises -> fail_cnt 1,2 then locked_out=1, fail_cnt=0, ticks_left=3; a pass during lockout is ignored; locked_out=0 after 12 cycles.
REQ-037 Second series of 3 fails with no pass between -> alarm toggles every 4 cycles, locked_out=0; inputs ignored until rst.
REQ-038 pass and fail rising in the same cycle from IDLE -> fail_cnt=1, unlocked=0.
REQ-039 rst pulsed mid-OPEN with ticks_left=1 -> all outputs 0 immediately; pass held high through rst release -> one OPEN entry only.
